// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write arbiter: output-stage
// state encoding and default address/data widths.
package regfile_pkg;

    // One-entry output stage occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_e;

    localparam int DEFAULT_AW = 5;
    localparam int DEFAULT_DW = 32;

endpackage

// File: rtl/regfile_arb_grant.sv
// Grant selection for the register-file write arbiter. Searches the valid
// vector starting at ptr (wrapping) and returns a one-hot grant for the
// first valid requester found. With ptr tied to zero this is plain
// lowest-index-wins fixed priority.
module regfile_arb_grant #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant
);

    int   idx;
    logic found;

    // Rotating first-valid search beginning at ptr
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter. NREQ requesters compete for a single
// write port through a one-entry output stage; the stage can retire and
// refill in the same cycle so back-to-back writes sustain one per cycle.
// Writes to register 0 are accepted and retired but never drive wrEnable.
// The pending entry is exposed on the fwd_* port so readers can bypass it.
// Build option: define REGFILE_ARB_RR_EN for round-robin arbitration;
// otherwise the lowest valid requester index always wins.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = DEFAULT_AW,
    parameter int DW   = DEFAULT_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*AW-1:0] req_reg,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic              wr_stall,
    output logic              wrEnable,
    output logic [AW-1:0]     wrReg,
    output logic [DW-1:0]     wrData,
    output logic              fwd_valid,
    output logic [AW-1:0]     fwd_reg,
    output logic [DW-1:0]     fwd_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    stage_e          state, stateNext;
    logic [AW-1:0]   entryReg_p1;
    logic [DW-1:0]   entryData_p1;
    logic [PW-1:0]   rrPtr;
    logic [NREQ-1:0] grant;
    logic            canAccept;
    logic            transfer;
    logic            retire;
    logic [AW-1:0]   selReg;
    logic [DW-1:0]   selData;

    regfile_arb_grant #(
        .NREQ (NREQ),
        .PW   (PW)
    ) uGrant (
        .valid (req_valid),
        .ptr   (rrPtr),
        .grant (grant)
    );

    // rst_n gates acceptance so no requester sees ready while held in reset
    assign canAccept = rst_n && ((state == EMPTY) || !wr_stall);
    assign req_ready = canAccept ? grant : '0;
    assign transfer  = |req_ready;
    assign retire    = (state == FULL) && !wr_stall;

    // Mux the granted requester's address and data into the stage
    always_comb begin
        selReg  = '0;
        selData = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                selReg  = req_reg[i*AW +: AW];
                selData = req_data[i*DW +: DW];
            end
        end
    end

`ifdef REGFILE_ARB_RR_EN
    logic [PW-1:0] grantIdx;

    // Index of the requester being transferred this cycle
    always_comb begin
        grantIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                grantIdx = PW'(i);
            end
        end
    end

    // Pointer moves just past the winner, only on a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr <= '0;
        end else if (transfer) begin
            rrPtr <= (int'(grantIdx) == NREQ - 1) ? '0 : grantIdx + 1'b1;
        end
    end
`else
    assign rrPtr = '0;
`endif

    // Stage occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // A refill keeps the stage FULL; a bare retire empties it
    always_comb begin
        stateNext = state;
        if (transfer) begin
            stateNext = FULL;
        end else if (retire) begin
            stateNext = EMPTY;
        end
    end

    // ---- stage p1: captured write entry ----
    // Entry contents are cleared on reset so the write and bypass ports read zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entryReg_p1  <= '0;
            entryData_p1 <= '0;
        end else if (transfer) begin
            entryReg_p1  <= selReg;
            entryData_p1 <= selData;
        end
    end

    assign wrEnable  = (state == FULL) && !wr_stall && (entryReg_p1 != '0);
    assign wrReg     = entryReg_p1;
    assign wrData    = entryData_p1;
    assign fwd_valid = (state == FULL) && (entryReg_p1 != '0);
    assign fwd_reg   = entryReg_p1;
    assign fwd_data  = entryData_p1;

endmodule
